ceespu: RTL and testbench

- Compact 32-bit load/store CPU core with 32 general registers and a 16-bit byte address space.
- Separate instruction and data ports. Instruction fetch is a combinational-read model: I_imemData must hold the word at O_imemAddress before the next rising edge.
- Nominally one instruction per cycle. Loads take at least 2 cycles. Data accesses stall on I_dmemBusy.
- One level of vectored interrupts.

---
 rtl/ceespu.sv | 138 +++++++++++++
 tb/tb_ceespu.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ceespu.sv
// ceespu: 32-bit load/store core, 32 registers, 16-bit address space, one level of vectored interrupts.
module ceespu #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] INT_BASE = 16'h0100
) (
  input  logic        I_clk,
  input  logic        I_rst,
  output logic [15:0] O_imemAddress,
  input  logic [31:0] I_imemData,
  output logic [15:0] O_dmemAddress,
  output logic [31:0] O_dmemWData,
  output logic        O_dmemE,
  output logic [3:0]  O_dmemWe,
  input  logic [31:0] I_dmemData,
  input  logic        I_dmemBusy,
  input  logic        I_int,
  input  logic [2:0]  I_int_vector,
  output logic        O_int_ack
);
  typedef enum logic {EXEC, LOAD} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, epc_q, epc_d, pc4, br_t, daddr;
  logic ie_q, ie_d, ack_q, ack_d, stall_q, stall_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_wd, imm_x, a_v, b_v, opnd, alu;
  logic rf_we, take, acc, ld, st, br_ok;
  logic [5:0] op;
  logic [4:0] rd, ra, rb, rb_sel;
  logic [15:0] imm;
  assign op = I_imemData[31:26];
  assign rd = I_imemData[25:21];
  assign ra = I_imemData[20:16];
  assign rb = I_imemData[15:11];
  assign imm = I_imemData[15:0];
  assign imm_x = {{16{imm[15]}}, imm};
  // Stores and branches compare/emit rd, so the second read port switches to rd for them.
  assign rb_sel = (op == 6'h12 || (op >= 6'h13 && op <= 6'h15)) ? rd : rb;
  assign a_v = (ra == 5'd0) ? 32'd0 : rf_q[ra];
  assign b_v = (rb_sel == 5'd0) ? 32'd0 : rf_q[rb_sel];
  assign opnd = op[3] ? imm_x : b_v;
  assign pc4 = pc_q + 16'd4;
  assign br_t = pc4 + {imm[13:0], 2'b00};
  assign daddr = a_v[15:0] + imm;
  assign br_ok = (op == 6'h13) ? (b_v == a_v) :
                 (op == 6'h14) ? (b_v != a_v) : ($signed(b_v) < $signed(a_v));
  assign take = state_q == EXEC && I_int && ie_q && !stall_q;
  assign acc = I_rst && state_q == EXEC && !take;
  assign ld = acc && op == 6'h11;
  assign st = acc && op == 6'h12;
  assign O_imemAddress = pc_q;
  assign O_dmemE = ld | st;
  assign O_dmemWe = st ? 4'hF : 4'h0;
  assign O_dmemAddress = (ld | st) ? daddr : 16'h0;
  assign O_dmemWData = st ? b_v : 32'd0;
  assign O_int_ack = ack_q;
  always_comb begin
    case (op[2:0])
      3'd0: alu = a_v + opnd;
      3'd1: alu = a_v - opnd;
      3'd2: alu = a_v & opnd;
      3'd3: alu = a_v | opnd;
      3'd4: alu = a_v ^ opnd;
      3'd5: alu = a_v << opnd[4:0];
      3'd6: alu = a_v >> opnd[4:0];
      default: alu = $unsigned($signed(a_v) >>> opnd[4:0]);
    endcase
  end
  always_comb begin
    pc_d = pc_q;
    state_d = state_q;
    ie_d = ie_q;
    epc_d = epc_q;
    ack_d = 1'b0;
    stall_d = 1'b0;
    rf_we = 1'b0;
    rf_wd = alu;
    if (state_q == LOAD) begin
      if (!I_dmemBusy) begin
        rf_we = 1'b1;
        rf_wd = I_dmemData;
        pc_d = pc4;
        state_d = EXEC;
      end
    end else if (take) begin
      epc_d = pc_q;
      ie_d = 1'b0;
      pc_d = INT_BASE + {9'd0, I_int_vector, 4'd0};
      ack_d = 1'b1;
    end else begin
      pc_d = pc4;
      case (op)
        6'h10: begin
          rf_we = 1'b1;
          rf_wd = {imm, 16'h0};
        end
        6'h11: begin
          pc_d = pc_q;
          state_d = LOAD;
        end
        6'h12: begin
          pc_d = I_dmemBusy ? pc_q : pc4;
          stall_d = I_dmemBusy;
        end
        6'h13, 6'h14, 6'h15: pc_d = br_ok ? br_t : pc4;
        6'h16: begin
          rf_we = 1'b1;
          rf_wd = {16'h0, pc4};
          pc_d = br_t;
        end
        6'h17: pc_d = a_v[15:0] & 16'hFFFC;
        6'h18: begin
          pc_d = epc_q;
          ie_d = 1'b1;
        end
        default: rf_we = op < 6'h10;
      endcase
    end
  end
  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      pc_q <= RESET_PC;
      state_q <= EXEC;
      ie_q <= 1'b1;
      epc_q <= 16'h0;
      ack_q <= 1'b0;
      stall_q <= 1'b0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      pc_q <= pc_d;
      state_q <= state_d;
      ie_q <= ie_d;
      epc_q <= epc_d;
      ack_q <= ack_d;
      stall_q <= stall_d;
      if (rf_we && rd != 5'd0) rf_q[rd] <= rf_wd;
    end
  end
endmodule

// File: tb/tb_ceespu.sv
// tb_ceespu: runs a small program against ceespu; completed stores are checked against a scoreboard queue.
module tb_ceespu;
  logic clk = 1'b0, rst = 1'b0;
  logic [15:0] imem_addr, dmem_addr;
  logic [31:0] imem_data, dmem_wdata, dmem_data;
  logic dmem_e, dmem_busy, irq, int_ack;
  logic [3:0] dmem_we;
  logic [2:0] irq_vec;
  logic [31:0] imem [128];
  logic [47:0] sb [$];
  logic [47:0] exp_st;
  int checks = 0, errors = 0, acks = 0;

  ceespu dut (
    .I_clk(clk), .I_rst(rst), .O_imemAddress(imem_addr), .I_imemData(imem_data),
    .O_dmemAddress(dmem_addr), .O_dmemWData(dmem_wdata), .O_dmemE(dmem_e), .O_dmemWe(dmem_we),
    .I_dmemData(dmem_data), .I_dmemBusy(dmem_busy), .I_int(irq), .I_int_vector(irq_vec),
    .O_int_ack(int_ack)
  );

  always #5 clk = ~clk;
  assign imem_data = imem[imem_addr[8:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd, ra, rb);
    return {op, rd, ra, rb, 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rd, ra, input logic [15:0] imm);
    return {op, rd, ra, imm};
  endfunction

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  always @(negedge clk) begin
    if (int_ack) acks++;
    if (rst && dmem_e && dmem_we == 4'hF && !dmem_busy) begin
      if (sb.size() == 0) check("sw_unexpected", 1, 0);
      else begin
        exp_st = sb.pop_front();
        check("sw_commit", {dmem_addr, dmem_wdata}, exp_st);
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) imem[i] = 32'd0;
    imem[0]  = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    imem[1]  = enc_i(6'h08, 5'd2, 5'd1, 16'hFFFD);
    imem[2]  = enc_i(6'h12, 5'd2, 5'd0, 16'h0010);
    imem[3]  = enc_i(6'h11, 5'd3, 5'd0, 16'h0004);
    imem[4]  = enc_r(6'h00, 5'd4, 5'd3, 5'd3);
    imem[5]  = enc_i(6'h12, 5'd4, 5'd0, 16'h0000);
    imem[6]  = enc_i(6'h16, 5'd31, 5'd0, 16'd1);
    imem[7]  = enc_i(6'h12, 5'd0, 5'd0, 16'h007C);
    imem[8]  = enc_i(6'h14, 5'd1, 5'd0, 16'hFFFF);
    imem[9]  = enc_i(6'h12, 5'd31, 5'd0, 16'h0020);
    imem[10] = enc_i(6'h10, 5'd7, 5'd0, 16'h8000);
    imem[11] = enc_i(6'h0F, 5'd8, 5'd7, 16'd4);
    imem[12] = enc_i(6'h0E, 5'd9, 5'd7, 16'd4);
    imem[13] = enc_r(6'h04, 5'd10, 5'd8, 5'd9);
    imem[14] = enc_i(6'h12, 5'd10, 5'd0, 16'h0024);
    imem[15] = enc_i(6'h15, 5'd8, 5'd0, 16'd1);
    imem[16] = enc_i(6'h12, 5'd0, 5'd0, 16'h007C);
    imem[17] = enc_i(6'h13, 5'd0, 5'd0, 16'hFFFF);
    imem[76] = enc_i(6'h08, 5'd1, 5'd0, 16'd0);
    imem[77] = enc_r(6'h18, 5'd0, 5'd0, 5'd0);
    sb.push_back({16'h0010, 32'd2});
    sb.push_back({16'h0000, 32'd4});
    sb.push_back({16'h0020, 32'h0000_001C});
    sb.push_back({16'h0024, 32'hF000_0000});
    dmem_busy = 1'b0;
    dmem_data = 32'd2;
    irq = 1'b0;
    irq_vec = 3'd3;
    repeat (2) step;
    check("rst_pc", imem_addr, 16'h0000);
    check("rst_dmem_e", dmem_e, 0);
    check("rst_we", dmem_we, 0);
    check("rst_ack", int_ack, 0);
    check("rst_daddr", dmem_addr, 0);
    rst = 1'b1;
    step;
    check("pc_4", imem_addr, 16'h0004);
    step;
    check("pc_8", imem_addr, 16'h0008);
    check("sw_e", dmem_e, 1);
    check("sw_we", dmem_we, 4'hF);
    check("sw_addr", dmem_addr, 16'h0010);
    check("sw_data", dmem_wdata, 32'd2);
    step;
    check("lw_pc", imem_addr, 16'h000C);
    check("lw_e", dmem_e, 1);
    check("lw_we", dmem_we, 0);
    check("lw_addr", dmem_addr, 16'h0004);
    step;
    check("load_pc_hold", imem_addr, 16'h000C);
    check("load_e", dmem_e, 0);
    step;
    check("after_lw_pc", imem_addr, 16'h0010);
    dmem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      check("stall_pc", imem_addr, 16'h0014);
      check("stall_e", dmem_e, 1);
      check("stall_data", dmem_wdata, 32'd4);
    end
    dmem_busy = 1'b0;
    step;
    check("sw_done_pc", imem_addr, 16'h0018);
    step;
    check("jal_pc", imem_addr, 16'h0020);
    step;
    check("bne_loop_pc", imem_addr, 16'h0020);
    irq = 1'b1;
    step;
    check("int_pc", imem_addr, 16'h0130);
    check("int_ack", int_ack, 1);
    step;
    check("int_masked_pc", imem_addr, 16'h0134);
    check("ack_pulse", int_ack, 0);
    irq = 1'b0;
    step;
    check("reti_pc", imem_addr, 16'h0020);
    step;
    check("bne_fall_pc", imem_addr, 16'h0024);
    for (int i = 0; i < 50 && imem_addr != 16'h0044; i++) step;
    check("reach_end", imem_addr, 16'h0044);
    step;
    check("end_loop_pc", imem_addr, 16'h0044);
    check("sb_drained", sb.size(), 0);
    check("ack_count", acks, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
